// File: rtl/parking_gate_arbiter_if.sv
// Request/grant and occupancy signals between the parking-gate arbiter and its
// surroundings (approach sensors, car_detect, actuator, counter/display block).
interface parking_gate_arbiter_if #(
   parameter int unsigned CW = 5
);
   logic          req_in;
   logic          req_out;
   logic          pass;
   logic          gate_open;
   logic          dir_in;
   logic          inc;
   logic          dec;
   logic          full;
   logic          empty;
   logic [CW-1:0] occupancy;
   logic          timeout_err;

   modport master (
      output req_in, req_out, pass,
      input  gate_open, dir_in, inc, dec, full, empty, occupancy, timeout_err
   );

   modport slave (
      input  req_in, req_out, pass,
      output gate_open, dir_in, inc, dec, full, empty, occupancy, timeout_err
   );
endinterface

// File: rtl/parking_gate_arbiter.sv
// Single-lane gate arbiter: round-robin entry/exit grants, pass/timeout handling,
// settle interval and occupancy tracking with inc/dec pulses.
module parking_gate_arbiter #(
   parameter int unsigned CAPACITY      = 25,
   parameter int unsigned CW            = 5,
   parameter int unsigned OPEN_CYCLES   = 50_000_000,
   parameter int unsigned SETTLE_CYCLES = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   parking_gate_arbiter_if.slave  bus
);
   localparam int unsigned TMAX = (OPEN_CYCLES > SETTLE_CYCLES) ? OPEN_CYCLES : SETTLE_CYCLES;
   localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

   typedef enum logic [1:0] {IDLE, GRANT_IN, GRANT_OUT, CLOSE} state_e;

   state_e          state_q, state_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic [CW-1:0]   occ_q, occ_d;
   logic            gate_open_q, gate_open_d;
   logic            dir_in_q, dir_in_d;
   logic            inc_q, inc_d;
   logic            dec_q, dec_d;
   logic            full_q, full_d;
   logic            empty_q, empty_d;
   logic            timeout_q, timeout_d;
   logic            elig_in, elig_out;

   assign elig_in  = bus.req_in  & ~full_q;
   assign elig_out = bus.req_out & ~empty_q;

   // dir_in_q doubles as the round-robin last-direction flag
   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      occ_d       = occ_q;
      gate_open_d = gate_open_q;
      dir_in_d    = dir_in_q;
      inc_d       = 1'b0;
      dec_d       = 1'b0;
      timeout_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (elig_in && (!elig_out || !dir_in_q)) begin
               state_d     = GRANT_IN;
               gate_open_d = 1'b1;
               dir_in_d    = 1'b1;
               timer_d     = '0;
            end else if (elig_out) begin
               state_d     = GRANT_OUT;
               gate_open_d = 1'b1;
               dir_in_d    = 1'b0;
               timer_d     = '0;
            end
         end
         GRANT_IN, GRANT_OUT: begin
            if (bus.pass) begin
               if (state_q == GRANT_IN) begin
                  if (occ_q != CW'(CAPACITY)) begin
                     occ_d = occ_q + CW'(1);
                     inc_d = 1'b1;
                  end
               end else if (occ_q != '0) begin
                  occ_d = occ_q - CW'(1);
                  dec_d = 1'b1;
               end
               gate_open_d = 1'b0;
               state_d     = CLOSE;
               timer_d     = '0;
            end else if (timer_q == TW'(OPEN_CYCLES - 1)) begin
               timeout_d   = 1'b1;
               gate_open_d = 1'b0;
               state_d     = CLOSE;
               timer_d     = '0;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         CLOSE: begin
            if (timer_q == TW'(SETTLE_CYCLES - 1)) begin
               state_d = IDLE;
               timer_d = '0;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         default: begin
            state_d     = IDLE;
            gate_open_d = 1'b0;
            timer_d     = '0;
         end
      endcase

      full_d  = (occ_d == CW'(CAPACITY));
      empty_d = (occ_d == '0);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         timer_q     <= '0;
         occ_q       <= '0;
         gate_open_q <= 1'b0;
         dir_in_q    <= 1'b0;
         inc_q       <= 1'b0;
         dec_q       <= 1'b0;
         full_q      <= 1'b0;
         empty_q     <= 1'b1;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         occ_q       <= occ_d;
         gate_open_q <= gate_open_d;
         dir_in_q    <= dir_in_d;
         inc_q       <= inc_d;
         dec_q       <= dec_d;
         full_q      <= full_d;
         empty_q     <= empty_d;
         timeout_q   <= timeout_d;
      end
   end

   assign bus.gate_open   = gate_open_q;
   assign bus.dir_in      = dir_in_q;
   assign bus.inc         = inc_q;
   assign bus.dec         = dec_q;
   assign bus.full        = full_q;
   assign bus.empty       = empty_q;
   assign bus.occupancy   = occ_q;
   assign bus.timeout_err = timeout_q;
endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Directed bench for parking_gate_arbiter: cycle vector table plus sequences for
// round-robin, full/empty blocking, timeout, pass-vs-timeout and async reset.
module tb_parking_gate_arbiter;
   localparam int unsigned CAPACITY      = 25;
   localparam int unsigned CW            = 5;
   localparam int unsigned OPEN_CYCLES   = 20;
   localparam int unsigned SETTLE_CYCLES = 4;

   logic clk;
   logic reset;
   int   checks;
   int   errors;
   int   exp_occ;

   parking_gate_arbiter_if #(.CW(CW)) bus ();

   parking_gate_arbiter #(
      .CAPACITY     (CAPACITY),
      .CW           (CW),
      .OPEN_CYCLES  (OPEN_CYCLES),
      .SETTLE_CYCLES(SETTLE_CYCLES)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // flags = {gate_open, dir_in, inc, dec, full, empty, timeout_err}
   typedef struct {
      logic          ri;
      logic          ro;
      logic          ps;
      logic [6:0]    flags;
      logic [CW-1:0] occ;
   } vec_t;

   vec_t tbl[18];

   function automatic vec_t mk(input logic ri, input logic ro, input logic ps,
                               input logic [6:0] flags, input int occ);
      vec_t v;
      v.ri = ri; v.ro = ro; v.ps = ps; v.flags = flags; v.occ = CW'(occ);
      return v;
   endfunction

   function automatic logic [6:0] obs_flags();
      return {bus.gate_open, bus.dir_in, bus.inc, bus.dec, bus.full, bus.empty, bus.timeout_err};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_open(output int closed);
      logic ok;
      ok     = 1'b0;
      closed = 0;
      for (int i = 0; i < 64; i++) begin
         tick();
         if (bus.gate_open) begin
            ok = 1'b1;
            break;
         end
         closed++;
      end
      check("gate_open_within_bound", 32'(ok), 32'd1);
   endtask

   // One car through the gate in the requested direction, pass right after opening
   task automatic car(input logic want_in);
      int gap;
      bus.req_in  = want_in;
      bus.req_out = ~want_in;
      wait_open(gap);
      bus.req_in  = 1'b0;
      bus.req_out = 1'b0;
      check("car_dir", 32'(bus.dir_in), 32'(want_in));
      bus.pass = 1'b1;
      tick();
      bus.pass = 1'b0;
      exp_occ = want_in ? exp_occ + 1 : exp_occ - 1;
      check("car_pulse", {30'd0, bus.inc, bus.dec}, want_in ? 32'd2 : 32'd1);
      check("car_occ", 32'(bus.occupancy), 32'(exp_occ));
      check("car_gate_closed", 32'(bus.gate_open), 32'd0);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      exp_occ = 0;
   endtask

   initial begin
      #200_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int gap;
      int n;
      int opens;
      checks = 0;
      errors = 0;
      exp_occ = 0;
      bus.req_in = 1'b0; bus.req_out = 1'b0; bus.pass = 1'b0;
      reset = 1'b1;

      tbl[0]  = mk(1, 0, 0, 7'b1100010, 0);
      tbl[1]  = mk(0, 0, 0, 7'b1100010, 0);
      tbl[2]  = mk(0, 0, 0, 7'b1100010, 0);
      tbl[3]  = mk(0, 0, 1, 7'b0110000, 1);
      tbl[4]  = mk(0, 0, 0, 7'b0100000, 1);
      tbl[5]  = mk(0, 0, 1, 7'b0100000, 1);
      tbl[6]  = mk(0, 0, 0, 7'b0100000, 1);
      tbl[7]  = mk(0, 0, 0, 7'b0100000, 1);
      tbl[8]  = mk(0, 0, 1, 7'b0100000, 1);
      tbl[9]  = mk(0, 1, 0, 7'b1000000, 1);
      tbl[10] = mk(0, 0, 1, 7'b0001010, 0);
      tbl[11] = mk(0, 0, 0, 7'b0000010, 0);
      tbl[12] = mk(0, 0, 0, 7'b0000010, 0);
      tbl[13] = mk(0, 0, 0, 7'b0000010, 0);
      tbl[14] = mk(0, 0, 0, 7'b0000010, 0);
      tbl[15] = mk(0, 1, 0, 7'b0000010, 0);
      tbl[16] = mk(1, 1, 0, 7'b1100010, 0);
      tbl[17] = mk(0, 0, 1, 7'b0110000, 1);

      do_reset();
      check("reset_state", {25'd0, obs_flags()}, {25'd0, 7'b0000010});
      check("reset_occ", 32'(bus.occupancy), 32'd0);

      for (int i = 0; i < 18; i++) begin
         bus.req_in  = tbl[i].ri;
         bus.req_out = tbl[i].ro;
         bus.pass    = tbl[i].ps;
         tick();
         checks++;
         if ({obs_flags(), bus.occupancy} !== {tbl[i].flags, tbl[i].occ}) begin
            errors++;
            $display("FAIL vec[%0d]: got flags=%b occ=%0d expected flags=%b occ=%0d",
                     i, obs_flags(), bus.occupancy, tbl[i].flags, tbl[i].occ);
         end
      end
      bus.req_in = 1'b0; bus.req_out = 1'b0; bus.pass = 1'b0;
      exp_occ = 1;

      // Round-robin with both requests held, starting from occupancy 5 after an exit
      for (int i = 0; i < 5; i++) car(1'b1);
      car(1'b0);
      bus.req_in  = 1'b1;
      bus.req_out = 1'b1;
      for (int g = 0; g < 6; g++) begin
         wait_open(gap);
         check("rr_dir", 32'(bus.dir_in), (g % 2 == 0) ? 32'd1 : 32'd0);
         if (g > 0) check("rr_closed_gap", 32'(gap + 1 >= int'(SETTLE_CYCLES)), 32'd1);
         bus.pass = 1'b1;
         tick();
         bus.pass = 1'b0;
         exp_occ = (g % 2 == 0) ? exp_occ + 1 : exp_occ - 1;
         check("rr_occ", 32'(bus.occupancy), 32'(exp_occ));
      end
      bus.req_in = 1'b0; bus.req_out = 1'b0;

      // Fill to capacity; entry must then stay blocked until an exit
      do_reset();
      for (int i = 0; i < int'(CAPACITY); i++) car(1'b1);
      check("full_flag", 32'(bus.full), 32'd1);
      bus.req_in = 1'b1;
      opens = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (bus.gate_open) opens++;
      end
      check("full_blocks_entry", 32'(opens), 32'd0);
      bus.req_out = 1'b1;
      wait_open(gap);
      check("full_exit_dir", 32'(bus.dir_in), 32'd0);
      bus.req_in = 1'b0; bus.req_out = 1'b0;
      bus.pass = 1'b1;
      tick();
      bus.pass = 1'b0;
      check("full_exit_dec", {30'd0, bus.inc, bus.dec}, 32'd1);
      check("full_exit_occ", 32'(bus.occupancy), 32'(CAPACITY - 1));
      check("full_cleared", 32'(bus.full), 32'd0);

      // Grant expires with no pass
      bus.req_in = 1'b1;
      wait_open(gap);
      bus.req_in = 1'b0;
      n = 1;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (!bus.gate_open) break;
         n++;
      end
      check("timeout_open_cycles", 32'(n), 32'(OPEN_CYCLES));
      check("timeout_pulse", {29'd0, bus.timeout_err, bus.inc, bus.dec}, 32'd4);
      check("timeout_occ", 32'(bus.occupancy), 32'(CAPACITY - 1));
      tick();
      check("timeout_one_pulse", 32'(bus.timeout_err), 32'd0);

      // pass arriving on the final open cycle beats the timeout
      bus.req_in = 1'b1;
      wait_open(gap);
      bus.req_in = 1'b0;
      repeat (OPEN_CYCLES - 1) tick();
      check("last_cycle_still_open", 32'(bus.gate_open), 32'd1);
      bus.pass = 1'b1;
      tick();
      bus.pass = 1'b0;
      check("pass_wins_pulses", {29'd0, bus.timeout_err, bus.inc, bus.dec}, 32'd2);
      check("pass_wins_occ", 32'(bus.occupancy), 32'(CAPACITY));
      check("pass_wins_full", 32'(bus.full), 32'd1);
      bus.pass = 1'b1;
      tick();
      bus.pass = 1'b0;
      check("pass_in_close", {30'd0, bus.inc, bus.dec}, 32'd0);
      check("pass_in_close_occ", 32'(bus.occupancy), 32'(CAPACITY));
      exp_occ = CAPACITY;
      car(1'b0);

      // Asynchronous reset in the middle of an entry grant
      bus.req_in = 1'b1;
      wait_open(gap);
      bus.req_in = 1'b0;
      tick();
      tick();
      #2 reset = 1'b0;
      #1;
      check("async_reset_gate", 32'(bus.gate_open), 32'd0);
      check("async_reset_occ", 32'(bus.occupancy), 32'd0);
      check("async_reset_flags", {25'd0, obs_flags()}, {25'd0, 7'b0000010});
      tick();
      reset = 1'b1;
      exp_occ = 0;
      bus.req_in  = 1'b1;
      bus.req_out = 1'b1;
      wait_open(gap);
      check("post_reset_first_dir", 32'(bus.dir_in), 32'd1);
      check("post_reset_latency", 32'(gap), 32'd0);
      bus.pass = 1'b1;
      tick();
      bus.pass = 1'b0;
      check("post_reset_inc", {30'd0, bus.inc, bus.dec}, 32'd2);
      wait_open(gap);
      check("post_reset_second_dir", 32'(bus.dir_in), 32'd0);
      bus.pass = 1'b1;
      tick();
      bus.pass = 1'b0;
      check("post_reset_dec", {30'd0, bus.inc, bus.dec}, 32'd1);
      check("post_reset_empty", 32'(bus.empty), 32'd1);
      bus.req_in = 1'b0; bus.req_out = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
